data_bus_ctrl: RTL and testbench
================================

DATA_BUS_CTRL -- requirements
Module: data_bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, giving the address width in bits.
REQ-002 SHALL have parameter WAIT_STATES, default 2, giving the number of extra strobe cycles (legal range 0..15).
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  access request; sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  ADDR_W  access address; sampled with req.
REQ-008 wdata  input  8  write data; sampled with req.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 ack  output  1  one-cycle completion pulse.
REQ-011 rdata  output  8  read result; valid from the ack cycle and held until the next read completes.
REQ-012 bus_addr  output  ADDR_W  address driven to the external bus.
REQ-013 bus_dout  output  8  data fed to the tri-state buffer input.
REQ-014 buf_en  output  1  tri-state buffer enable: 0 = buffer drives the bus, 1 = high-Z.
REQ-015 we_n  output  1  active-low write strobe.
REQ-016 oe_n  output  1  active-low output-enable (read) strobe.
REQ-017 bus_din  input  8  resolved bus value, read back from the shared bus.

Function
REQ-018 SHALL implement the FSM IDLE -> SETUP -> ACCESS -> HOLD -> IDLE, with no other states or transitions.
REQ-019 In IDLE, req=1 SHALL latch we, addr and wdata and move to SETUP on the next edge; req=0 keeps the FSM in IDLE.
REQ-020 req SHALL be ignored in all other states, and no request queue SHALL exist.
REQ-021 bus_addr and bus_dout SHALL drive the latched values from SETUP through HOLD and stay stable throughout.
REQ-022 In IDLE, bus_addr SHALL hold its last value.
REQ-023 For a write, buf_en SHALL be 0 in SETUP, ACCESS and HOLD, and 1 in IDLE.
REQ-024 For a write, we_n SHALL be 0 only in ACCESS.
REQ-025 For a read, buf_en SHALL be 1 in every state.
REQ-026 For a read, oe_n SHALL be 0 in SETUP and ACCESS, and 1 in HOLD.
REQ-027 ACCESS SHALL last exactly WAIT_STATES+1 cycles, timed by a 4-bit down-counter loaded on entry.
REQ-028 On a read, rdata SHALL capture bus_din on the last ACCESS cycle (the edge that enters HOLD).
REQ-029 ack SHALL be 1 only in HOLD, for exactly one cycle per access.
REQ-030 Request-to-ack latency SHALL be WAIT_STATES+3 cycles after the req sampling edge.
REQ-031 buf_en=0 and oe_n=0 SHALL never occur in the same cycle.
REQ-032 we_n=0 and oe_n=0 SHALL never occur in the same cycle.
REQ-033 After HOLD, the FSM SHALL always spend at least one cycle in IDLE, giving the bus a turnaround cycle.

Reset
REQ-034 rst=1 at a clock edge SHALL force the following values from any state, including mid-access: FSM=IDLE, busy=0, ack=0, buf_en=1, we_n=1, oe_n=1, rdata=0, bus_addr=0, bus_dout=0, counter=0.
REQ-035 An access interrupted by reset SHALL be abandoned and SHALL produce no ack.

Structure
REQ-036 FSM state encodings and the default ADDR_W/WAIT_STATES values SHALL reside in a shared package, data_bus_pkg.
REQ-037 The block SHALL instantiate one sub-module, the existing 8-bit tri-state buffer, with in=bus_dout and EN=buf_en.
REQ-038 The buffer output SHALL be exported as an inout bus port, data_bus[7:0], and bus_din SHALL be tied to that port.

Verification
REQ-039 Write, WAIT_STATES=2: req=1, we=1, addr=16'h1234, wdata=8'hA5 at cycle 0 -> the bench SHALL check buf_en=0 and bus_dout=A5 in cycles 1-4, we_n=0 in cycles 2-4 only, ack=1 in cycle 5 only, and buf_en=1 in cycle 6.
REQ-040 Read, WAIT_STATES=2: bus model returns 8'h3C at addr 16'h00FF -> the bench SHALL check oe_n=0 in cycles 1-4, buf_en=1 throughout, and rdata=3C with ack=1 in cycle 5.
REQ-041 WAIT_STATES=0 -> the bench SHALL check that ACCESS lasts 1 cycle and ack arrives 3 cycles after req.
REQ-042 req held high continuously -> the bench SHALL check accesses complete with ack one cycle apart from IDLE re-entry, ack period WAIT_STATES+4, and no strobe overlap.
REQ-043 rst asserted during ACCESS of a write -> the bench SHALL check that on the next cycle we_n=1, buf_en=1, busy=0, and that ack never pulses for that access.
REQ-044 Every test -> a continuous assertion SHALL confirm that buf_en=0 never coincides with oe_n=0.

Source files
------------

// File: rtl/data_bus_pkg.sv
// Shared definitions for the external data bus controller: FSM encoding and
// default geometry.
package data_bus_pkg;

   localparam int DEF_ADDR_W      = 16;
   localparam int DEF_WAIT_STATES = 2;
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

endpackage

// File: rtl/data_bus_ctrl_tribuf.sv
// 8-bit tri-state buffer: drives 'in' onto 'out' while EN is low, releases the
// bus (high-Z) while EN is high.
module data_bus_ctrl_tribuf (
   input  logic [7:0] in,
   input  logic       EN,
   output wire  [7:0] out
);

   assign out = EN ? 8'bz : in;

endmodule

// File: rtl/data_bus_ctrl.sv
// Single-master controller for an asynchronous SRAM-style bus: one access at a
// time through SETUP / ACCESS / HOLD with a programmable number of wait states.
module data_bus_ctrl
   import data_bus_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int WAIT_STATES = DEF_WAIT_STATES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic              busy,
   output logic              ack,
   output logic [7:0]        rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        bus_dout,
   output logic              buf_en,
   output logic              we_n,
   output logic              oe_n,
   inout  wire  [7:0]        data_bus,
   output logic [1:0]        dbg_state
);

   // Handshake: req/we/addr/wdata are sampled only on an edge where the FSM is
   // in IDLE; ack is a single-cycle pulse in HOLD. There is no queue, so a req
   // seen while busy=1 is simply ignored and must be held or re-issued.

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             lat_we;
   logic [7:0]       bus_din;

   assign bus_din   = data_bus;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         lat_we   <= 1'b0;
         bus_addr <= '0;
         bus_dout <= '0;
         rdata    <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_IDLE && req) begin
            lat_we   <= we;
            bus_addr <= addr;
            bus_dout <= wdata;
         end
         // Loaded on the SETUP->ACCESS edge; ACCESS exits when it reads zero.
         if (state == ST_SETUP)
            cnt <= CNT_W'(WAIT_STATES);
         else if (state == ST_ACCESS && cnt != '0)
            cnt <= cnt - 1'b1;
         if (state == ST_ACCESS && cnt == '0 && !lat_we)
            rdata <= bus_din;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b1;
      ack      = 1'b0;
      buf_en   = 1'b1;
      we_n     = 1'b1;
      oe_n     = 1'b1;
      unique case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (req) state_nx = ST_SETUP;
         end
         ST_SETUP: begin
            buf_en   = !lat_we;
            oe_n     = lat_we;
            state_nx = ST_ACCESS;
         end
         ST_ACCESS: begin
            buf_en = !lat_we;
            we_n   = !lat_we;
            oe_n   = lat_we;
            if (cnt == '0) state_nx = ST_HOLD;
         end
         ST_HOLD: begin
            // Buffer keeps driving for write hold time; read strobe already off.
            buf_en   = !lat_we;
            ack      = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   data_bus_ctrl_tribuf u_tribuf (
      .in  (bus_dout),
      .EN  (buf_en),
      .out (data_bus)
   );

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl: table of per-cycle vectors for a write and
// a read, then hand sequences for zero wait states, back-to-back req and reset.
module tb_data_bus_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // DUT with WAIT_STATES=2
   logic        rst, req, we;
   logic [15:0] addr, bus_addr;
   logic [7:0]  wdata, rdata, bus_dout;
   logic        busy, ack, buf_en, we_n, oe_n;
   logic [1:0]  dbg_state;
   wire  [7:0]  data_bus;

   // DUT with WAIT_STATES=0
   logic        req0, we0;
   logic [15:0] addr0, bus_addr0;
   logic [7:0]  wdata0, rdata0, bus_dout0;
   logic        busy0, ack0, buf_en0, we_n0, oe_n0;
   logic [1:0]  dbg_state0;
   wire  [7:0]  data_bus0;

   // Memory model: answers reads while oe_n is low, 3C at 00FF, EE elsewhere
   assign data_bus  = !oe_n  ? ((bus_addr  == 16'h00FF) ? 8'h3C : 8'hEE) : 8'bz;
   assign data_bus0 = !oe_n0 ? ((bus_addr0 == 16'h00FF) ? 8'h3C : 8'hEE) : 8'bz;

   data_bus_ctrl #(.ADDR_W(16), .WAIT_STATES(2)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy), .ack(ack), .rdata(rdata), .bus_addr(bus_addr),
      .bus_dout(bus_dout), .buf_en(buf_en), .we_n(we_n), .oe_n(oe_n),
      .data_bus(data_bus), .dbg_state(dbg_state)
   );

   data_bus_ctrl #(.ADDR_W(16), .WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
      .busy(busy0), .ack(ack0), .rdata(rdata0), .bus_addr(bus_addr0),
      .bus_dout(bus_dout0), .buf_en(buf_en0), .we_n(we_n0), .oe_n(oe_n0),
      .data_bus(data_bus0), .dbg_state(dbg_state0)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Strobe exclusivity on both instances, every cycle outside reset
   always @(negedge clk) begin
      if (!rst) begin
         tests++;
         assert (!(!buf_en && !oe_n) && !(!we_n && !oe_n) &&
                 !(!buf_en0 && !oe_n0) && !(!we_n0 && !oe_n0))
         else begin
            fails++;
            $display("FAIL strobe_overlap: buf_en=%b we_n=%b oe_n=%b / buf_en0=%b we_n0=%b oe_n0=%b",
                     buf_en, we_n, oe_n, buf_en0, we_n0, oe_n0);
         end
      end
   end

   typedef struct {
      logic        req;
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        busy;
      logic        ack;
      logic        buf_en;
      logic        we_n;
      logic        oe_n;
      logic [15:0] bus_addr;
      logic [7:0]  bus_dout;
      logic [7:0]  rdata;
   } vec_t;

   vec_t vecs[14];

   initial begin
      int ack_c[8];
      int n_ack, access_cnt, ack_cyc;
      logic prev_ack;

      //           req we  addr      wdata  busy ack ben wen oen bus_addr  dout   rdata
      // write 1234 <= A5: SETUP c1, ACCESS c2-4, HOLD c5, IDLE c6
      vecs[0]  = '{1'b1, 1'b1, 16'h1234, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 8'h00, 8'h00};
      vecs[1]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 8'hA5, 8'h00};
      vecs[2]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00};
      vecs[3]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00};
      vecs[4]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00};
      vecs[5]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 8'hA5, 8'h00};
      vecs[6]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 8'hA5, 8'h00};
      // read 00FF (memory returns 3C): oe_n low c1-4, rdata valid with ack c5
      vecs[7]  = '{1'b1, 1'b0, 16'h00FF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 8'hA5, 8'h00};
      vecs[8]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF, 8'h00, 8'h00};
      vecs[9]  = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF, 8'h00, 8'h00};
      vecs[10] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF, 8'h00, 8'h00};
      vecs[11] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h00FF, 8'h00, 8'h00};
      vecs[12] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00FF, 8'h00, 8'h3C};
      vecs[13] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00FF, 8'h00, 8'h3C};

      // clock/reset
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_state", 32'(dbg_state), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_buf_en", 32'(buf_en), 32'd1);
      check("rst_we_n", 32'(we_n), 32'd1);
      check("rst_oe_n", 32'(oe_n), 32'd1);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_bus_addr", 32'(bus_addr), 32'd0);
      check("rst_bus_dout", 32'(bus_dout), 32'd0);
      @(posedge clk); #1;

      // table-driven write + read
      for (int i = 0; i < 14; i++) begin
         req = vecs[i].req; we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
         @(negedge clk);
         check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         check($sformatf("v%0d_ack", i), 32'(ack), 32'(vecs[i].ack));
         check($sformatf("v%0d_buf_en", i), 32'(buf_en), 32'(vecs[i].buf_en));
         check($sformatf("v%0d_we_n", i), 32'(we_n), 32'(vecs[i].we_n));
         check($sformatf("v%0d_oe_n", i), 32'(oe_n), 32'(vecs[i].oe_n));
         check($sformatf("v%0d_bus_addr", i), 32'(bus_addr), 32'(vecs[i].bus_addr));
         check($sformatf("v%0d_bus_dout", i), 32'(bus_dout), 32'(vecs[i].bus_dout));
         check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].rdata));
         if (!vecs[i].buf_en)
            check($sformatf("v%0d_data_bus", i), 32'(data_bus), 32'(vecs[i].bus_dout));
         @(posedge clk); #1;
      end

      // WAIT_STATES=0 read: ACCESS for one cycle, ack 3 cycles after req
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h00FF; wdata0 = 8'h00;
      ack_cyc = -1; access_cnt = 0; n_ack = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (dbg_state0 == 2'd2) access_cnt++;
         if (ack0) begin
            n_ack++;
            if (ack_cyc < 0) ack_cyc = k;
            check("ws0_rdata", 32'(rdata0), 32'h3C);
         end
         @(posedge clk); #1;
         if (k == 0) req0 = 1'b0;
      end
      check("ws0_ack_latency", 32'(ack_cyc), 32'd3);
      check("ws0_access_len", 32'(access_cnt), 32'd1);
      check("ws0_ack_count", 32'(n_ack), 32'd1);

      // req held high: acks at 5, 11, 17 with IDLE after every HOLD
      req = 1'b1; we = 1'b1; addr = 16'h0ABC; wdata = 8'h77;
      n_ack = 0; prev_ack = 1'b0;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         if (prev_ack) check("b2b_turnaround_busy", 32'(busy), 32'd0);
         prev_ack = ack;
         if (ack) begin
            if (n_ack < 8) ack_c[n_ack] = k;
            n_ack++;
         end
         @(posedge clk); #1;
      end
      req = 1'b0;
      check("b2b_ack_count", 32'(n_ack), 32'd3);
      if (n_ack >= 3) begin
         check("b2b_first_ack", 32'(ack_c[0]), 32'd5);
         check("b2b_period_1", 32'(ack_c[1] - ack_c[0]), 32'd6);
         check("b2b_period_2", 32'(ack_c[2] - ack_c[1]), 32'd6);
      end

      // reset in the middle of a write's ACCESS phase
      req = 1'b1; we = 1'b1; addr = 16'h5555; wdata = 8'h5A;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rstw_in_access", 32'(dbg_state), 32'd2);
      check("rstw_we_n_low", 32'(we_n), 32'd0);
      check("rstw_rdata_held", 32'(rdata), 32'h3C);
      @(posedge clk); #1;
      rst = 1'b1;
      n_ack = 0;
      @(negedge clk);
      if (ack) n_ack++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rstw_we_n", 32'(we_n), 32'd1);
      check("rstw_buf_en", 32'(buf_en), 32'd1);
      check("rstw_busy", 32'(busy), 32'd0);
      check("rstw_oe_n", 32'(oe_n), 32'd1);
      check("rstw_rdata", 32'(rdata), 32'd0);
      check("rstw_bus_addr", 32'(bus_addr), 32'd0);
      check("rstw_bus_dout", 32'(bus_dout), 32'd0);
      for (int k = 0; k < 10; k++) begin
         if (ack) n_ack++;
         @(negedge clk);
      end
      check("rstw_no_ack", 32'(n_ack), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
